mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
- Single-master memory port arbiter between the instruction cache read-fill port, data cache read-fill port and data cache write-back port, and the external synchronous memory.
- Sits directly downstream of both caches in the cpu top and drives the cpu memory ports (mem_enable, mem_rw, mem_addr, mem_data_in; receives mem_ack, mem_data_out).
- One memory transaction in flight at a time.
- Grants, holds request fields stable until mem_ack, then returns a one-cycle ack (plus line data for reads) to the winning client.

Parameters:
- ADDR_W, 32 (`REG_SIZE), byte address width.
- LINE_W, 128 (`WIDTH), memory/cache line width in bits.

Ports:
- clk  in  1  clock; all logic on posedge.
- reset  in  1  synchronous active-high reset.
- ic_read_req  in  1  I-cache line fill request; held until ic_read_ack.
- ic_read_addr  in  ADDR_W  I-cache fill address.
- ic_read_ack  out  1  one-cycle pulse; ic_read_data valid this cycle.
- ic_read_data  out  LINE_W  fill line for I-cache.
- dc_read_req  in  1  D-cache line fill request.
- dc_read_addr  in  ADDR_W  D-cache fill address.
- dc_read_ack  out  1  one-cycle pulse; dc_read_data valid.
- dc_read_data  out  LINE_W  fill line for D-cache.
- dc_write_req  in  1  D-cache write-back request.
- dc_write_addr  in  ADDR_W  write-back address.
- dc_write_data  in  LINE_W  write-back line.
- dc_write_ack  out  1  one-cycle pulse; write completed.
- mem_enable  out  1  memory request valid.
- mem_rw  out  1  1 = write, 0 = read.
- mem_ack  in  1  memory completion pulse.
- mem_addr  out  ADDR_W  memory address.
- mem_data_in  out  LINE_W  write data to memory.
- mem_data_out  in  LINE_W  read data from memory.

Behaviour:
- Reset values:
  - state = IDLE.
  - mem_enable, mem_rw and all *_ack outputs are 0.
  - mem_addr, mem_data_in, ic_read_data and dc_read_data are 0.
- FSM states:
  - IDLE: if any request is high at the clock edge, latch the winner's id, address, rw and write data into registers, then go to BUSY. Otherwise stay in IDLE.
  - BUSY: mem_enable = 1, with mem_rw, mem_addr and mem_data_in driven from the registers and stable for the whole state. When mem_ack = 1, capture mem_data_out into the winner's data register, then go to RESP.
  - RESP: the winner's *_ack = 1 for exactly this cycle and mem_enable = 0; next state is IDLE.
- Latency: request sampled at edge t gives mem_enable high from t+1. mem_ack seen at edge k gives client ack high in cycle k+1. Minimum total is 3 cycles (IDLE, BUSY, RESP) with zero-wait memory.
- Client rule: request must be low in the cycle after its ack. The arbiter samples requests again only in IDLE, so no double grant occurs.
- Ack timing: read data outputs hold their last captured value. Ack is never asserted outside RESP.
- mem_ack in IDLE or RESP is ignored; it produces no state change and no ack.
- Request changes in BUSY are ignored. The latched grant wins.
- Simultaneous requests in IDLE are resolved by the grant selector (fixed priority, see Optional Feature). Losers stay pending and are granted on a later IDLE.
- Reset mid-operation (BUSY or RESP): return to IDLE next cycle, drop mem_enable, issue no ack. A stale mem_ack afterwards is ignored.
- Addresses and data pass through unmodified. No alignment and no width conversion.

Optional Feature:
- Macro ARB_RR_EN.
- Undefined: fixed priority dc_write > dc_read > ic_read, so write-backs drain before the fill that caused them.
- Defined: round-robin among the three sources.
  - A 2-bit last-grant pointer, reset to ic_read, updates on each grant.
  - The search starts from the source after last-grant, in the order ic_read → dc_read → dc_write → ic_read.

Decomposition:
- Shared package holds:
  - State encoding: IDLE = 2'd0, BUSY = 2'd1, RESP = 2'd2.
  - Grant id encoding: GNT_IC = 2'd0, GNT_DR = 2'd1, GNT_DW = 2'd2.
  - Defaults for ADDR_W and LINE_W tied to `REG_SIZE and `WIDTH.
- One sub-module, arb_grant_sel: combinational selector taking the three requests and the last-grant pointer, outputting a grant id and valid. The ARB_RR_EN logic lives here.

Test Plan:
- Reset, then ic_read_req = 1, addr = 0x100. Memory acks 2 cycles after mem_enable with data 0xA5…A5 → mem_enable = 1, rw = 0, addr = 0x100; ic_read_ack pulses one cycle with ic_read_data = 0xA5…A5.
- dc_read_req at 0x200 and dc_write_req at 0x300 (data 0x11…11) raised in the same cycle, fixed priority → write granted first (mem_rw = 1, mem_data_in = 0x11…11, dc_write_ack), then read at 0x200.
- ic_read_req held and dc_read_req toggled on every IDLE, with ARB_RR_EN defined → grants alternate IC/DR/IC; no source is starved.
- reset asserted in BUSY before mem_ack → IDLE next cycle, mem_enable = 0, no ack. A subsequent stray mem_ack produces no ack.
- mem_ack pulsed while IDLE with no requests → all outputs unchanged, state stays IDLE.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared types and defaults for the memory port arbiter.
// Optional feature macro: ARB_RR_EN (round-robin grant instead of fixed priority).
// REG_SIZE / WIDTH fall back to 32 / 128 when the surrounding cpu build
// has not defined them.

`ifndef REG_SIZE
`define REG_SIZE 32
`endif
`ifndef WIDTH
`define WIDTH 128
`endif

package mem_arbiter_pkg;

    localparam int DEF_ADDR_W = `REG_SIZE;
    localparam int DEF_LINE_W = `WIDTH;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } arb_state_e;

    typedef enum logic [1:0] {
        GNT_IC = 2'd0,
        GNT_DR = 2'd1,
        GNT_DW = 2'd2
    } gnt_id_e;

    // Next source in the round-robin ring ic_read -> dc_read -> dc_write -> ic_read.
    function automatic gnt_id_e next_src(input gnt_id_e cur);
        case (cur)
            GNT_IC:  return GNT_DR;
            GNT_DR:  return GNT_DW;
            default: return GNT_IC;
        endcase
    endfunction

    // Walk the ring a given number of steps from a starting source.
    function automatic gnt_id_e step_src(input gnt_id_e cur, input int steps);
        gnt_id_e s;
        s = cur;
        for (int i = 0; i < steps; i++) begin
            s = next_src(s);
        end
        return s;
    endfunction

endpackage

// File: rtl/mem_arbiter_grant_sel.sv
// arb_grant_sel: combinational grant selector for the memory arbiter.
// Optional feature macro: ARB_RR_EN. Undefined: fixed priority
// dc_write > dc_read > ic_read. Defined: round-robin starting after last_gnt.

module arb_grant_sel
    import mem_arbiter_pkg::*;
(
    input  logic    ic_req,
    input  logic    dr_req,
    input  logic    dw_req,
    input  gnt_id_e last_gnt,
    output gnt_id_e gnt_id,
    output logic    gnt_valid
);

    // Requests indexed by grant id.
    logic [2:0] req_vec;
    assign req_vec = {dw_req, dr_req, ic_req};

`ifdef ARB_RR_EN
    // Candidate gi is the source gi+1 steps after the last grant.
    gnt_id_e    cand [3];
    logic [2:0] cand_req;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_cand
            assign cand[gi] = step_src(last_gnt, gi + 1);
            always_comb begin
                case (cand[gi])
                    GNT_IC:  cand_req[gi] = req_vec[0];
                    GNT_DR:  cand_req[gi] = req_vec[1];
                    GNT_DW:  cand_req[gi] = req_vec[2];
                    default: cand_req[gi] = 1'b0;
                endcase
            end
        end
    endgenerate

    // Pick the first requesting candidate in ring order.
    always_comb begin
        gnt_valid = |cand_req;
        gnt_id    = cand[2];
        if (cand_req[1]) gnt_id = cand[1];
        if (cand_req[0]) gnt_id = cand[0];
    end
`else
    // The pointer only matters for round-robin; fold it away here.
    logic unused_last_gnt;
    assign unused_last_gnt = ^last_gnt;

    // Write-backs drain before the fill that evicted them.
    always_comb begin
        gnt_valid = |req_vec;
        gnt_id    = GNT_IC;
        if (dw_req) begin
            gnt_id = GNT_DW;
        end else if (dr_req) begin
            gnt_id = GNT_DR;
        end
    end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: single-master arbiter between I-cache fill, D-cache fill and
// D-cache write-back ports and one external synchronous memory.
// One transaction in flight: IDLE (sample/grant) -> BUSY (hold until
// mem_ack) -> RESP (one-cycle client ack).
// Optional feature macro: ARB_RR_EN (round-robin grant, see arb_grant_sel).

module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int LINE_W = DEF_LINE_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ic_read_req,
    input  logic [ADDR_W-1:0] ic_read_addr,
    output logic              ic_read_ack,
    output logic [LINE_W-1:0] ic_read_data,
    input  logic              dc_read_req,
    input  logic [ADDR_W-1:0] dc_read_addr,
    output logic              dc_read_ack,
    output logic [LINE_W-1:0] dc_read_data,
    input  logic              dc_write_req,
    input  logic [ADDR_W-1:0] dc_write_addr,
    input  logic [LINE_W-1:0] dc_write_data,
    output logic              dc_write_ack,
    output logic              mem_enable,
    output logic              mem_rw,
    input  logic              mem_ack,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [LINE_W-1:0] mem_data_in,
    input  logic [LINE_W-1:0] mem_data_out
);

    arb_state_e        state_reg, state_next;
    gnt_id_e           gnt_reg;
    gnt_id_e           last_gnt_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic              rw_reg;
    logic [LINE_W-1:0] wdata_reg;
    logic [LINE_W-1:0] ic_data_reg;
    logic [LINE_W-1:0] dc_data_reg;

    gnt_id_e           sel_id;
    logic              sel_valid;
    logic [ADDR_W-1:0] sel_addr;
    logic              take_grant;
    logic              take_ack;
    logic [2:0]        ack_vec;

    arb_grant_sel u_grant_sel (
        .ic_req    (ic_read_req),
        .dr_req    (dc_read_req),
        .dw_req    (dc_write_req),
        .last_gnt  (last_gnt_reg),
        .gnt_id    (sel_id),
        .gnt_valid (sel_valid)
    );

    // Requests are only looked at in IDLE; mem_ack only counts in BUSY.
    assign take_grant = (state_reg == IDLE) && sel_valid;
    assign take_ack   = (state_reg == BUSY) && mem_ack;

    // Address of whichever client the selector picked.
    always_comb begin
        case (sel_id)
            GNT_DW:  sel_addr = dc_write_addr;
            GNT_DR:  sel_addr = dc_read_addr;
            default: sel_addr = ic_read_addr;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (sel_valid) state_next = BUSY;
            BUSY:    if (mem_ack) state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Memory-side handshake outputs.
    always_comb begin
        mem_enable = 1'b0;
        mem_rw     = 1'b0;
        case (state_reg)
            BUSY: begin
                mem_enable = 1'b1;
                mem_rw     = rw_reg;
            end
            default: begin
                mem_enable = 1'b0;
                mem_rw     = 1'b0;
            end
        endcase
    end

    // One ack per client, raised only in RESP for the latched winner.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_ack
            assign ack_vec[gi] = (state_reg == RESP) && (gnt_reg == gnt_id_e'(gi));
        end
    endgenerate

    assign ic_read_ack  = ack_vec[GNT_IC];
    assign dc_read_ack  = ack_vec[GNT_DR];
    assign dc_write_ack = ack_vec[GNT_DW];

    assign mem_addr     = addr_reg;
    assign mem_data_in  = wdata_reg;
    assign ic_read_data = ic_data_reg;
    assign dc_read_data = dc_data_reg;

    // Latch the grant in IDLE; capture read data on the accepted mem_ack.
    always_ff @(posedge clk) begin
        if (reset) begin
            gnt_reg      <= GNT_IC;
            last_gnt_reg <= GNT_IC;
            addr_reg     <= '0;
            rw_reg       <= 1'b0;
            wdata_reg    <= '0;
            ic_data_reg  <= '0;
            dc_data_reg  <= '0;
        end else begin
            if (take_grant) begin
                gnt_reg      <= sel_id;
                last_gnt_reg <= sel_id;
                addr_reg     <= sel_addr;
                rw_reg       <= (sel_id == GNT_DW);
                wdata_reg    <= (sel_id == GNT_DW) ? dc_write_data : '0;
            end
            if (take_ack) begin
                if (gnt_reg == GNT_IC) ic_data_reg <= mem_data_out;
                if (gnt_reg == GNT_DR) dc_data_reg <= mem_data_out;
            end
        end
    end

endmodule
